// File: rtl/floo_mbox_pkg.sv
// floo_mbox_pkg: shared types for the mailbox/doorbell NoC responder.
//   - id_t            : mesh coordinate of a tile (same layout as the NoC id).
//   - mbox_kind_e     : request flit kinds (AW, W, AR).
//   - mbox_rsp_kind_e : response flit kinds (B, R).
//   - mbox_req_flit_t / mbox_rsp_flit_t : narrow request / response flits.
//   - RespOkay / RespSlvErr / RespDecErr : AXI response codes.
//   - mbox_state_e    : responder FSM states.
//   - strb_to_mask    : byte strobe to 64-bit bit-mask expansion.
package floo_mbox_pkg;

    localparam int unsigned MboxAddrWidth = 48;
    localparam int unsigned MboxIdWidth   = 4;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } id_t;

    typedef enum logic [1:0] {
        KindAw = 2'd0,
        KindW  = 2'd1,
        KindAr = 2'd2
    } mbox_kind_e;

    typedef enum logic {
        KindB = 1'b0,
        KindR = 1'b1
    } mbox_rsp_kind_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef struct packed {
        id_t                      src_id;
        mbox_kind_e               kind;
        logic [MboxIdWidth-1:0]   axi_id;
        logic [MboxAddrWidth-1:0] addr;
        logic [7:0]               len;
        logic [63:0]              data;
        logic [7:0]               strb;
        logic                     last;
    } mbox_req_flit_t;

    typedef struct packed {
        id_t                    dst_id;
        id_t                    src_id;
        mbox_rsp_kind_e         kind;
        logic [MboxIdWidth-1:0] axi_id;
        logic [1:0]             resp;
        logic [63:0]            data;
        logic                   last;
    } mbox_rsp_flit_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrData = 2'd1,
        StWrResp = 2'd2,
        StRdResp = 2'd3
    } mbox_state_e;

    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        for (int b = 0; b < 8; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/floo_mbox_regfile.sv
// floo_mbox_regfile: NumRegs x 64-bit mailbox registers.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (clears all registers)
//   we_i         : write enable for one byte-strobed write this cycle
//   widx_i       : register index written
//   wdata_i      : write data
//   wstrb_i      : byte strobes, one per data byte
//   ridx_i       : register index read (combinational read mux)
//   rdata_o      : read data
//   irq_o        : per-register level interrupt, high while the register is non-zero
module floo_mbox_regfile
    import floo_mbox_pkg::*;
#(
    parameter int unsigned NumRegs = 8,
    parameter int unsigned IdxW    = $clog2(NumRegs)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [IdxW-1:0]    widx_i,
    input  logic [63:0]        wdata_i,
    input  logic [7:0]         wstrb_i,
    input  logic [IdxW-1:0]    ridx_i,
    output logic [63:0]        rdata_o,
    output logic [NumRegs-1:0] irq_o
);

    logic [63:0] regs_q [NumRegs];
    logic [63:0] wmask;

    assign wmask = strb_to_mask(wstrb_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[widx_i] <= (regs_q[widx_i] & ~wmask) | (wdata_i & wmask);
        end
    end

    assign rdata_o = regs_q[ridx_i];

    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            irq_o[i] = |regs_q[i];
        end
    end

endmodule

// File: rtl/floo_mbox_responder.sv
// floo_mbox_responder: NoC endpoint terminating the narrow request link and
// answering AXI-over-flit accesses to a small doorbell/mailbox register file.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   id_i           : own mesh coordinate, returned as rsp_o.src_id
//   req_valid_i/req_ready_o/req_i : request flit handshake (AW, W, AR)
//   rsp_valid_o/rsp_ready_i/rsp_o : response flit handshake (B, R)
//   irq_o          : one level interrupt per register (register non-zero)
//   proto_err_o    : sticky flag, set on a flit kind illegal in the current state
// Build option: define FLOO_MBOX_RSP_CUT_EN to insert a one-entry spill
// register on the response path (response appears one cycle later).
module floo_mbox_responder
    import floo_mbox_pkg::*;
#(
    parameter int unsigned          NumRegs   = 8,
    parameter int unsigned          AddrWidth = 48,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          IdWidth   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  id_t                id_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  mbox_req_flit_t     req_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output mbox_rsp_flit_t     rsp_o,
    output logic [NumRegs-1:0] irq_o,
    output logic               proto_err_o
);

    localparam int unsigned          IdxW    = $clog2(NumRegs);
    localparam logic [AddrWidth-1:0] RegSpan = AddrWidth'(NumRegs * 8);

    mbox_state_e          state_q, state_d;
    id_t                  src_q, src_d;
    logic [IdWidth-1:0]   axi_id_q, axi_id_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [1:0]           resp_q, resp_d;
    logic                 proto_err_q, proto_err_d;

    logic                 req_ready;
    logic                 wr_en;
    logic [63:0]          rd_data;
    logic                 int_valid;
    logic                 int_ready;
    mbox_rsp_flit_t       int_rsp;

    // Address decode of the incoming AW/AR. An address below BaseAddr wraps
    // to a huge offset and therefore decodes as out of range.
    logic [AddrWidth-1:0] req_offset;
    logic                 req_in_range;
    logic [1:0]           req_resp;

    assign req_offset   = AddrWidth'(req_i.addr) - BaseAddr;
    assign req_in_range = (req_offset < RegSpan) && (req_offset[2:0] == 3'b000);
    assign req_resp     = !req_in_range       ? RespDecErr :
                          (req_i.len != 8'd0) ? RespSlvErr : RespOkay;

    floo_mbox_regfile #(
        .NumRegs (NumRegs),
        .IdxW    (IdxW)
    ) i_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_en),
        .widx_i  (idx_q),
        .wdata_i (req_i.data),
        .wstrb_i (req_i.strb),
        .ridx_i  (idx_q),
        .rdata_o (rd_data),
        .irq_o   (irq_o)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        axi_id_d    = axi_id_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        proto_err_d = proto_err_q;
        req_ready   = 1'b0;
        wr_en       = 1'b0;
        int_valid   = 1'b0;
        int_rsp     = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid_i) begin
                    case (req_i.kind)
                        KindAw, KindAr: begin
                            src_d    = req_i.src_id;
                            axi_id_d = IdWidth'(req_i.axi_id);
                            idx_d    = req_offset[IdxW+2:3];
                            cnt_d    = req_i.len;
                            resp_d   = req_resp;
                            state_d  = (req_i.kind == KindAw) ? StWrData : StRdResp;
                        end
                        default: proto_err_d = 1'b1;
                    endcase
                end
            end
            StWrData: begin
                req_ready = 1'b1;
                if (req_valid_i) begin
                    if (req_i.kind == KindW) begin
                        // Bursts and bad addresses drain their beats without
                        // touching the register file.
                        wr_en = (resp_q == RespOkay);
                        if (req_i.last) begin
                            state_d = StWrResp;
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            StWrResp: begin
                int_valid      = 1'b1;
                int_rsp.dst_id = src_q;
                int_rsp.src_id = id_i;
                int_rsp.kind   = KindB;
                int_rsp.axi_id = MboxIdWidth'(axi_id_q);
                int_rsp.resp   = resp_q;
                int_rsp.last   = 1'b1;
                if (int_ready) begin
                    state_d = StIdle;
                end
            end
            StRdResp: begin
                int_valid      = 1'b1;
                int_rsp.dst_id = src_q;
                int_rsp.src_id = id_i;
                int_rsp.kind   = KindR;
                int_rsp.axi_id = MboxIdWidth'(axi_id_q);
                int_rsp.resp   = resp_q;
                int_rsp.data   = (resp_q == RespOkay) ? rd_data : 64'd0;
                int_rsp.last   = (cnt_q == 8'd0);
                // cnt counts remaining beats after this one, so len=255
                // yields 256 beats before reaching zero.
                if (int_ready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            src_q       <= '0;
            axi_id_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            resp_q      <= RespOkay;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            axi_id_q    <= axi_id_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign req_ready_o = req_ready & ~rst_i;
    assign proto_err_o = proto_err_q;

`ifdef FLOO_MBOX_RSP_CUT_EN
    // One-entry pipeline register: accepts a new beat whenever it is empty
    // or its current beat is leaving, so valid never depends on ready.
    logic           spill_full_q;
    mbox_rsp_flit_t spill_q;

    assign int_ready = ~spill_full_q | rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spill_full_q <= 1'b0;
            spill_q      <= '0;
        end else if (int_ready) begin
            spill_full_q <= int_valid;
            spill_q      <= int_valid ? int_rsp : '0;
        end
    end

    assign rsp_valid_o = spill_full_q;
    assign rsp_o       = spill_q;
`else
    assign int_ready   = rsp_ready_i;
    assign rsp_valid_o = int_valid;
    assign rsp_o       = int_rsp;
`endif

endmodule

// File: tb/tb_floo_mbox_responder.sv
module tb_floo_mbox_responder;
    import floo_mbox_pkg::*;

    localparam int unsigned NREGS = 8;
    localparam logic [47:0] BASE  = 48'h1000;
    localparam id_t OWN     = '{x: 3'd1, y: 3'd2};
    localparam id_t REQ_SRC = '{x: 3'd4, y: 3'd5};

    logic           clk = 1'b0;
    logic           rst_i;
    logic           req_valid_i;
    logic           req_ready_o;
    mbox_req_flit_t req_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    mbox_rsp_flit_t rsp_o;
    logic [NREGS-1:0] irq_o;
    logic           proto_err_o;

    floo_mbox_responder #(
        .NumRegs   (NREGS),
        .AddrWidth (48),
        .BaseAddr  (BASE),
        .IdWidth   (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .id_i        (OWN),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_i       (req_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_o       (rsp_o),
        .irq_o       (irq_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    mbox_rsp_flit_t exp_q[$];

    function automatic mbox_req_flit_t mk_req(input mbox_kind_e k, input logic [3:0] id,
                                              input logic [47:0] a, input logic [7:0] len,
                                              input logic [63:0] d, input logic [7:0] s,
                                              input logic last);
        mbox_req_flit_t f;
        f        = '0;
        f.src_id = REQ_SRC;
        f.kind   = k;
        f.axi_id = id;
        f.addr   = a;
        f.len    = len;
        f.data   = d;
        f.strb   = s;
        f.last   = last;
        return f;
    endfunction

    function automatic mbox_rsp_flit_t mk_rsp(input mbox_rsp_kind_e k, input logic [3:0] id,
                                              input logic [1:0] resp, input logic [63:0] d,
                                              input logic last);
        mbox_rsp_flit_t r;
        r        = '0;
        r.dst_id = REQ_SRC;
        r.src_id = OWN;
        r.kind   = k;
        r.axi_id = id;
        r.resp   = resp;
        r.data   = d;
        r.last   = last;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one request flit; returns at posedge+1 after its handshake.
    task automatic send(input mbox_req_flit_t f);
        int n;
        n = 0;
        req_i       = f;
        req_valid_i = 1'b1;
        while (!req_ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready_o) begin
            chk("req_ready_timeout", 64'(req_ready_o), 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        req_i       = '0;
    endtask

    // Response must be visible one cycle after the accepting edge (two with the cut).
    task automatic chk_lat(input string name);
`ifdef FLOO_MBOX_RSP_CUT_EN
        chk({name, "_early"}, 64'(rsp_valid_o), 64'd0);
        @(posedge clk);
        #1;
`endif
        chk(name, 64'(rsp_valid_o), 64'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            chk({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks
    // that a stalled response is held unchanged.
    initial begin
        mbox_rsp_flit_t prev_rsp;
        mbox_rsp_flit_t e;
        logic stall_prev;
        stall_prev = 1'b0;
        prev_rsp   = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!rsp_valid_o || rsp_o !== prev_rsp) begin
                        fails++;
                        $display("FAIL rsp_hold: got v=%0d %h want v=1 %h", rsp_valid_o, rsp_o, prev_rsp);
                    end
                end
                if (rsp_valid_o && rsp_ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL rsp_unexpected: got %h want none", rsp_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (rsp_o !== e) begin
                            fails++;
                            $display("FAIL rsp_flit: got %h want %h", rsp_o, e);
                        end
                    end
                end
                stall_prev = rsp_valid_o && !rsp_ready_i;
                prev_rsp   = rsp_o;
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_i       = '0;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", 64'(req_ready_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_zero", 64'(rsp_o == '0), 64'd1);
        chk("rst_irq", 64'(irq_o), 64'd0);
        chk("rst_proto_err", 64'(proto_err_o), 64'd0);
        @(posedge clk);
        #1;

        // Full write of reg1.
        send(mk_req(KindAw, 4'd1, BASE + 48'd8, 8'd0, 64'd0, 8'd0, 1'b0));
        exp_q.push_back(mk_rsp(KindB, 4'd1, RespOkay, 64'd0, 1'b1));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'hDEAD_BEEF, 8'hFF, 1'b1));
        chk_lat("b_latency");
        drain("wr_reg1");
        chk("irq_reg1", 64'(irq_o), 64'h02);

        // Read back reg1.
        exp_q.push_back(mk_rsp(KindR, 4'd3, RespOkay, 64'hDEAD_BEEF, 1'b1));
        send(mk_req(KindAr, 4'd3, BASE + 48'd8, 8'd0, 64'd0, 8'd0, 1'b0));
        chk_lat("r_latency");
        drain("rd_reg1");

        // Write just past the last register: DECERR, nothing written.
        send(mk_req(KindAw, 4'd2, BASE + 48'd64, 8'd0, 64'd0, 8'd0, 1'b0));
        exp_q.push_back(mk_rsp(KindB, 4'd2, RespDecErr, 64'd0, 1'b1));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'hAAAA_5555, 8'hFF, 1'b1));
        drain("wr_oob");
        chk("irq_after_oob", 64'(irq_o), 64'h02);

        // Out-of-range read burst: 4 zero beats, DECERR, last only on beat 4.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk_rsp(KindR, 4'd4, RespDecErr, 64'd0, (i == 3)));
        end
        send(mk_req(KindAr, 4'd4, BASE + 48'd64, 8'd3, 64'd0, 8'd0, 1'b0));
        drain("rd_oob_burst");

        // Write burst to reg2: both beats consumed, single SLVERR, no update.
        send(mk_req(KindAw, 4'd5, BASE + 48'd16, 8'd1, 64'd0, 8'd0, 1'b0));
        exp_q.push_back(mk_rsp(KindB, 4'd5, RespSlvErr, 64'd0, 1'b1));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'h1234, 8'hFF, 1'b0));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'h5678, 8'hFF, 1'b1));
        drain("wr_burst");
        chk("irq_after_burst", 64'(irq_o), 64'h02);

        // Misaligned write into reg0's span: DECERR, no update.
        send(mk_req(KindAw, 4'd6, BASE + 48'd4, 8'd0, 64'd0, 8'd0, 1'b0));
        exp_q.push_back(mk_rsp(KindB, 4'd6, RespDecErr, 64'd0, 1'b1));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'h77, 8'hFF, 1'b1));
        drain("wr_misaligned");
        chk("irq_after_misaligned", 64'(irq_o), 64'h02);

        // Stray W in IDLE: consumed, sticky error; next AR still works.
        chk("proto_err_before", 64'(proto_err_o), 64'd0);
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'h99, 8'hFF, 1'b1));
        chk("proto_err_set", 64'(proto_err_o), 64'd1);
        chk("stray_no_rsp", 64'(rsp_valid_o), 64'd0);
        exp_q.push_back(mk_rsp(KindR, 4'd7, RespOkay, 64'hDEAD_BEEF, 1'b1));
        send(mk_req(KindAr, 4'd7, BASE + 48'd8, 8'd0, 64'd0, 8'd0, 1'b0));
        drain("rd_after_stray");
        chk("proto_err_sticky", 64'(proto_err_o), 64'd1);

        // Partial strobe write over an existing value in reg3.
        send(mk_req(KindAw, 4'd8, BASE + 48'd24, 8'd0, 64'd0, 8'd0, 1'b0));
        exp_q.push_back(mk_rsp(KindB, 4'd8, RespOkay, 64'd0, 1'b1));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'h1111_2222_3333_4444, 8'hFF, 1'b1));
        drain("wr_reg3_full");
        send(mk_req(KindAw, 4'd9, BASE + 48'd24, 8'd0, 64'd0, 8'd0, 1'b0));
        exp_q.push_back(mk_rsp(KindB, 4'd9, RespOkay, 64'd0, 1'b1));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1));
        drain("wr_reg3_partial");
        chk("irq_reg1_reg3", 64'(irq_o), 64'h0A);

        // Read reg3 while the downstream stalls for 5 cycles.
        rsp_ready_i = 1'b0;
        exp_q.push_back(mk_rsp(KindR, 4'd10, RespOkay, 64'h1111_2222_FFFF_FFFF, 1'b1));
        send(mk_req(KindAr, 4'd10, BASE + 48'd24, 8'd0, 64'd0, 8'd0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_req_ready", 64'(req_ready_o), 64'd0);
            chk("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
        end
        rsp_ready_i = 1'b1;
        drain("rd_reg3_stall");

        // Burst read at a valid address, len=255: 256 SLVERR beats.
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(mk_rsp(KindR, 4'd11, RespSlvErr, 64'd0, (i == 255)));
        end
        send(mk_req(KindAr, 4'd11, BASE, 8'd255, 64'd0, 8'd0, 1'b0));
        drain("rd_len255");
        chk("idle_after_len255", 64'(req_ready_o), 64'd1);

        // Reset while a B is pending: response discarded, registers cleared.
        rsp_ready_i = 1'b0;
        send(mk_req(KindAw, 4'd12, BASE + 48'd40, 8'd0, 64'd0, 8'd0, 1'b0));
        send(mk_req(KindW, 4'd0, 48'd0, 8'd0, 64'h5, 8'hFF, 1'b1));
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("midrst_irq", 64'(irq_o), 64'd0);
        chk("midrst_proto_err", 64'(proto_err_o), 64'd0);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk_rsp(KindR, 4'd13, RespOkay, 64'd0, 1'b1));
        send(mk_req(KindAr, 4'd13, BASE + 48'd8, 8'd0, 64'd0, 8'd0, 1'b0));
        drain("rd_after_reset");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
